mem_arbiter: RTL and testbench

Shares the single external memory bus port between the instruction-fetch requester and the data-memory (load/store) requester of the five-stage pipeline. It runs a request/acknowledge bus with variable latency and raises stall requests to `ctrl` until each requester's transfer completes. It holds completed results while `stop_all` freezes the owning stage. It sits between `pc_reg`/`if_id` and `mem` on one side and the external memory bus on the other.

---
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the single external request/acknowledge memory bus between instruction fetch and
// load/store, stalling each requester until its transfer completes and holding results while frozen.
module mem_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int SELECT_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [5:0]               stop_all,
    input  logic                     if_request_input,
    input  logic [ADDRESS_WIDTH-1:0] if_address_input,
    output logic [DATA_WIDTH-1:0]    if_data_output,
    output logic                     if_stall_request_output,
    input  logic                     mem_request_input,
    input  logic                     mem_write_enable_input,
    input  logic [SELECT_WIDTH-1:0]  mem_select_input,
    input  logic [ADDRESS_WIDTH-1:0] mem_address_input,
    input  logic [DATA_WIDTH-1:0]    mem_data_input,
    output logic [DATA_WIDTH-1:0]    mem_data_output,
    output logic                     mem_stall_request_output,
    output logic                     bus_request_output,
    output logic                     bus_write_enable_output,
    output logic [SELECT_WIDTH-1:0]  bus_select_output,
    output logic [ADDRESS_WIDTH-1:0] bus_address_output,
    output logic [DATA_WIDTH-1:0]    bus_data_output,
    input  logic [DATA_WIDTH-1:0]    bus_data_input,
    input  logic                     bus_ack_input
);

    localparam int IF_STAGE  = 1;
    localparam int MEM_STAGE = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_IF_BUSY  = 3'd1,
        ST_MEM_BUSY = 3'd2,
        ST_IF_HOLD  = 3'd3,
        ST_MEM_HOLD = 3'd4
    } state_e;

    state_e                   state_q, state_d;
    logic                     bus_req_q, bus_req_d;
    logic                     bus_we_q, bus_we_d;
    logic [SELECT_WIDTH-1:0]  bus_sel_q, bus_sel_d;
    logic [ADDRESS_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_WIDTH-1:0]    bus_wdata_q, bus_wdata_d;
    logic [DATA_WIDTH-1:0]    if_result_q, if_result_d;
    logic [DATA_WIDTH-1:0]    mem_result_q, mem_result_d;
    logic                     if_ack_s, mem_ack_s;
    logic                     unused_stop_s;

    // Only the IF and MEM freeze bits matter to this block.
    assign unused_stop_s = ^{stop_all[5], stop_all[3:2], stop_all[0]};

    assign if_ack_s  = (state_q == ST_IF_BUSY)  && bus_ack_input;
    assign mem_ack_s = (state_q == ST_MEM_BUSY) && bus_ack_input;

    assign if_stall_request_output  = if_request_input && !if_ack_s && (state_q != ST_IF_HOLD);
    assign mem_stall_request_output = mem_request_input && !mem_ack_s && (state_q != ST_MEM_HOLD);

    // The ack cycle forwards the bus data directly so the stage can advance in that same cycle.
    assign if_data_output  = if_ack_s  ? bus_data_input : if_result_q;
    assign mem_data_output = mem_ack_s ? bus_data_input : mem_result_q;

    assign bus_request_output      = bus_req_q;
    assign bus_write_enable_output = bus_we_q;
    assign bus_select_output       = bus_sel_q;
    assign bus_address_output      = bus_addr_q;
    assign bus_data_output         = bus_wdata_q;

    // Next-state, bus-cycle launch and result capture.
    always_comb begin
        state_d      = state_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_sel_d    = bus_sel_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        if_result_d  = if_result_q;
        mem_result_d = mem_result_q;
        case (state_q)
            ST_IDLE: begin
                // Data side wins a tie: it belongs to the older instruction.
                if (mem_request_input) begin
                    state_d     = ST_MEM_BUSY;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_write_enable_input;
                    bus_sel_d   = mem_select_input;
                    bus_addr_d  = mem_address_input;
                    bus_wdata_d = mem_data_input;
                end else if (if_request_input) begin
                    state_d     = ST_IF_BUSY;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_sel_d   = {SELECT_WIDTH{1'b1}};
                    bus_addr_d  = if_address_input;
                    bus_wdata_d = {DATA_WIDTH{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_IF_BUSY: begin
                if (bus_ack_input) begin
                    if_result_d = bus_data_input;
                    bus_req_d   = 1'b0;
                    if (stop_all[IF_STAGE]) begin
                        state_d = ST_IF_HOLD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IF_BUSY;
                end
            end
            ST_MEM_BUSY: begin
                if (bus_ack_input) begin
                    mem_result_d = bus_we_q ? {DATA_WIDTH{1'b0}} : bus_data_input;
                    bus_req_d    = 1'b0;
                    if (stop_all[MEM_STAGE]) begin
                        state_d = ST_MEM_HOLD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_MEM_BUSY;
                end
            end
            ST_IF_HOLD: begin
                if (stop_all[IF_STAGE]) begin
                    state_d = ST_IF_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEM_HOLD: begin
                if (stop_all[MEM_STAGE]) begin
                    state_d = ST_MEM_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // State, bus and result registers; reset abandons any bus cycle in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_sel_q    <= {SELECT_WIDTH{1'b0}};
            bus_addr_q   <= {ADDRESS_WIDTH{1'b0}};
            bus_wdata_q  <= {DATA_WIDTH{1'b0}};
            if_result_q  <= {DATA_WIDTH{1'b0}};
            mem_result_q <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_sel_q    <= bus_sel_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            if_result_q  <= if_result_d;
            mem_result_q <= mem_result_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cycle tables, hand-written hold/slow-bus sequences, and a
// randomized run checked every cycle against a transfer-level reference model.
module tb_mem_arbiter;

    logic        clock;
    logic        reset;
    logic [5:0]  stop_all;
    logic        ifr;
    logic [31:0] ifa;
    logic [31:0] if_data;
    logic        if_stall;
    logic        mr;
    logic        mwe;
    logic [3:0]  msel;
    logic [31:0] ma;
    logic [31:0] md;
    logic [31:0] mem_data;
    logic        mem_stall;
    logic        breq;
    logic        bwe;
    logic [3:0]  bsel;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [31:0] bdata;
    logic        back;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    mem_arbiter dut (
        .clock                    (clock),
        .reset                    (reset),
        .stop_all                 (stop_all),
        .if_request_input         (ifr),
        .if_address_input         (ifa),
        .if_data_output           (if_data),
        .if_stall_request_output  (if_stall),
        .mem_request_input        (mr),
        .mem_write_enable_input   (mwe),
        .mem_select_input         (msel),
        .mem_address_input        (ma),
        .mem_data_input           (md),
        .mem_data_output          (mem_data),
        .mem_stall_request_output (mem_stall),
        .bus_request_output       (breq),
        .bus_write_enable_output  (bwe),
        .bus_select_output        (bsel),
        .bus_address_output       (baddr),
        .bus_data_output          (bwdata),
        .bus_data_input           (bdata),
        .bus_ack_input            (back)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: one outstanding transfer (owner 0 = fetch, 1 = data), optionally parked
    // in a hold after completion, plus the last result delivered to each requester.
    logic        m_busy  = 1'b0;
    logic        m_hold  = 1'b0;
    logic        m_owner = 1'b0;
    logic        m_req   = 1'b0;
    logic        m_we    = 1'b0;
    logic [3:0]  m_sel   = 4'd0;
    logic [31:0] m_addr  = 32'd0;
    logic [31:0] m_wd    = 32'd0;
    logic [31:0] m_res [2];

    wire m_frozen = m_owner ? stop_all[4] : stop_all[1];
    wire m_ackd   = m_busy & back;

    always @(posedge clock) begin
        if (reset) begin
            m_busy   <= 1'b0;
            m_hold   <= 1'b0;
            m_owner  <= 1'b0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_sel    <= 4'd0;
            m_addr   <= 32'd0;
            m_wd     <= 32'd0;
            m_res[0] <= 32'd0;
            m_res[1] <= 32'd0;
        end else if (m_hold) begin
            if (!m_frozen) m_hold <= 1'b0;
        end else if (m_busy) begin
            if (back) begin
                m_res[m_owner] <= m_we ? 32'd0 : bdata;
                m_req  <= 1'b0;
                m_busy <= 1'b0;
                m_hold <= m_frozen;
            end
        end else if (mr || ifr) begin
            m_busy  <= 1'b1;
            m_req   <= 1'b1;
            m_owner <= mr;
            m_addr  <= mr ? ma : ifa;
            m_sel   <= mr ? msel : 4'hF;
            m_we    <= mr & mwe;
            m_wd    <= mr ? md : 32'd0;
        end
    end

    wire        e_if_stall  = ifr & ~(m_ackd & ~m_owner) & ~(m_hold & ~m_owner);
    wire        e_mem_stall = mr  & ~(m_ackd &  m_owner) & ~(m_hold &  m_owner);
    wire [31:0] e_if_data   = (m_ackd & ~m_owner) ? bdata : m_res[0];
    wire [31:0] e_mem_data  = (m_ackd &  m_owner) ? bdata : m_res[1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic model_check();
        chk1("model if_stall", if_stall, e_if_stall);
        chk1("model mem_stall", mem_stall, e_mem_stall);
        chk("model if_data", if_data, e_if_data);
        chk("model mem_data", mem_data, e_mem_data);
        chk1("model bus_req", breq, m_req);
        if (m_busy) begin
            chk("model bus_addr", baddr, m_addr);
            chk("model bus_sel", {28'd0, bsel}, {28'd0, m_sel});
            chk1("model bus_we", bwe, m_we);
            if (m_we) chk("model bus_wdata", bwdata, m_wd);
        end
    endtask

    // Advance to mid-cycle (outputs settled, away from the edge) and run the model comparison.
    task automatic to_neg();
        @(negedge clock);
        if (chk_en) model_check();
    endtask

    task automatic to_next();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        reset = 1'b0; stop_all = 6'd0; ifr = 1'b0; ifa = 32'd0;
        mr = 1'b0; mwe = 1'b0; msel = 4'd0; ma = 32'd0; md = 32'd0;
        back = 1'b0; bdata = 32'd0;
    endtask

    typedef struct {
        logic        rst;
        logic [5:0]  stop;
        logic        ifr;
        logic [31:0] ifa;
        logic        mr;
        logic        mwe;
        logic [3:0]  msel;
        logic [31:0] ma;
        logic [31:0] md;
        logic        ack;
        logic [31:0] bd;
        logic        e_ifs;
        logic        e_ms;
        logic        e_breq;
        logic        cb;
        logic [31:0] e_addr;
        logic [3:0]  e_sel;
        logic        e_we;
        logic        cw;
        logic [31:0] e_wd;
        logic [31:0] e_ifd;
        logic [31:0] e_md;
    } vec_t;

    function automatic vec_t v(
        logic rst, logic [5:0] stop, logic ifr_, logic [31:0] ifa_, logic mr_, logic mwe_,
        logic [3:0] msel_, logic [31:0] ma_, logic [31:0] md_, logic ack, logic [31:0] bd,
        logic e_ifs, logic e_ms, logic e_breq, logic cb, logic [31:0] e_addr, logic [3:0] e_sel,
        logic e_we, logic cw, logic [31:0] e_wd, logic [31:0] e_ifd, logic [31:0] e_md);
        vec_t r;
        r.rst = rst; r.stop = stop; r.ifr = ifr_; r.ifa = ifa_; r.mr = mr_; r.mwe = mwe_;
        r.msel = msel_; r.ma = ma_; r.md = md_; r.ack = ack; r.bd = bd;
        r.e_ifs = e_ifs; r.e_ms = e_ms; r.e_breq = e_breq; r.cb = cb; r.e_addr = e_addr;
        r.e_sel = e_sel; r.e_we = e_we; r.cw = cw; r.e_wd = e_wd; r.e_ifd = e_ifd; r.e_md = e_md;
        return r;
    endfunction

    vec_t tbl[$];

    initial begin
        // Columns: rst stop ifr ifa mr mwe msel ma md ack bd | ifs ms breq cb addr sel we cw wd ifd md
        // reset state
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0,                      0,0,0,1,0,0,0,1,0,0,0));
        // fetch only, ack in the third cycle of the request
        tbl.push_back(v(0,0,1,32'h100,0,0,0,0,0,0,0,                1,0,0,1,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,1,32'h100,0,0,0,0,0,0,0,                1,0,1,1,32'h100,4'hF,0,0,0,0,0));
        tbl.push_back(v(0,0,1,32'h100,0,0,0,0,0,1,32'h3401_1100,    0,0,1,1,32'h100,4'hF,0,0,0,32'h3401_1100,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0,                      0,0,0,0,0,0,0,0,0,32'h3401_1100,0));
        // simultaneous load and fetch: load first, one idle cycle, then fetch
        tbl.push_back(v(0,0,1,32'h104,1,0,4'hF,32'h40,0,0,0,        1,1,0,0,0,0,0,0,0,32'h3401_1100,0));
        tbl.push_back(v(0,0,1,32'h104,1,0,4'hF,32'h40,0,0,0,        1,1,1,1,32'h40,4'hF,0,0,0,32'h3401_1100,0));
        tbl.push_back(v(0,0,1,32'h104,1,0,4'hF,32'h40,0,1,32'hCAFE_0001, 1,0,1,1,32'h40,4'hF,0,0,0,32'h3401_1100,32'hCAFE_0001));
        tbl.push_back(v(0,0,1,32'h104,0,0,0,0,0,0,0,                1,0,0,0,0,0,0,0,0,32'h3401_1100,32'hCAFE_0001));
        tbl.push_back(v(0,0,1,32'h104,0,0,0,0,0,0,0,                1,0,1,1,32'h104,4'hF,0,0,0,32'h3401_1100,32'hCAFE_0001));
        tbl.push_back(v(0,0,1,32'h104,0,0,0,0,0,1,32'h13,           0,0,1,1,32'h104,4'hF,0,0,0,32'h13,32'hCAFE_0001));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0,                      0,0,0,0,0,0,0,0,0,32'h13,32'hCAFE_0001));
        // store
        tbl.push_back(v(0,0,0,0,1,1,4'b0011,32'h80,32'hDEAD_BEEF,0,0, 0,1,0,0,0,0,0,0,0,32'h13,32'hCAFE_0001));
        tbl.push_back(v(0,0,0,0,1,1,4'b0011,32'h80,32'hDEAD_BEEF,0,0, 0,1,1,1,32'h80,4'b0011,1,1,32'hDEAD_BEEF,32'h13,32'hCAFE_0001));
        tbl.push_back(v(0,0,0,0,1,1,4'b0011,32'h80,32'hDEAD_BEEF,0,0, 0,1,1,1,32'h80,4'b0011,1,1,32'hDEAD_BEEF,32'h13,32'hCAFE_0001));
        tbl.push_back(v(0,0,0,0,1,1,4'b0011,32'h80,32'hDEAD_BEEF,1,0, 0,0,1,1,32'h80,4'b0011,1,1,32'hDEAD_BEEF,32'h13,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0,                      0,0,0,0,0,0,0,0,0,32'h13,0));
        // reset during MEM_BUSY, late ack afterwards
        tbl.push_back(v(0,0,0,0,1,0,4'hF,32'h44,0,0,0,              0,1,0,0,0,0,0,0,0,32'h13,0));
        tbl.push_back(v(1,0,0,0,1,0,4'hF,32'h44,0,0,0,              0,1,1,1,32'h44,4'hF,0,0,0,32'h13,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,1,32'h5555_5555,          0,0,0,1,0,0,0,1,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0,                      0,0,0,1,0,0,0,1,0,0,0));

        idle_in();
        reset = 1'b1;
        to_next();
        to_next();
        chk_en = 1'b1;

        foreach (tbl[i]) begin
            reset = tbl[i].rst; stop_all = tbl[i].stop; ifr = tbl[i].ifr; ifa = tbl[i].ifa;
            mr = tbl[i].mr; mwe = tbl[i].mwe; msel = tbl[i].msel; ma = tbl[i].ma; md = tbl[i].md;
            back = tbl[i].ack; bdata = tbl[i].bd;
            to_neg();
            chk1($sformatf("row%0d if_stall", i), if_stall, tbl[i].e_ifs);
            chk1($sformatf("row%0d mem_stall", i), mem_stall, tbl[i].e_ms);
            chk1($sformatf("row%0d bus_req", i), breq, tbl[i].e_breq);
            chk($sformatf("row%0d if_data", i), if_data, tbl[i].e_ifd);
            chk($sformatf("row%0d mem_data", i), mem_data, tbl[i].e_md);
            if (tbl[i].cb) begin
                chk($sformatf("row%0d bus_addr", i), baddr, tbl[i].e_addr);
                chk($sformatf("row%0d bus_sel", i), {28'd0, bsel}, {28'd0, tbl[i].e_sel});
                chk1($sformatf("row%0d bus_we", i), bwe, tbl[i].e_we);
            end
            if (tbl[i].cw) chk($sformatf("row%0d bus_wdata", i), bwdata, tbl[i].e_wd);
            to_next();
        end

        // Hold: fetch acked while IF is frozen, released after three frozen cycles.
        idle_in();
        ifr = 1'b1; ifa = 32'h200;
        to_neg(); chk1("hold start stall", if_stall, 1'b1); to_next();
        to_neg(); chk("hold busy addr", baddr, 32'h200); to_next();
        back = 1'b1; bdata = 32'h1234_5678; stop_all = 6'b000011;
        to_neg();
        chk("hold ack data", if_data, 32'h1234_5678);
        chk1("hold ack stall", if_stall, 1'b0);
        to_next();
        bdata = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            to_neg();
            chk($sformatf("hold%0d data", k), if_data, 32'h1234_5678);
            chk1($sformatf("hold%0d stall", k), if_stall, 1'b0);
            chk1($sformatf("hold%0d bus_req", k), breq, 1'b0);
            to_next();
        end
        stop_all = 6'd0; back = 1'b0;
        to_neg(); chk("hold release data", if_data, 32'h1234_5678); chk1("hold release stall", if_stall, 1'b0); to_next();
        ifa = 32'h204;
        to_neg(); chk1("hold idle stall", if_stall, 1'b1); chk1("hold idle bus_req", breq, 1'b0); to_next();
        back = 1'b1; bdata = 32'h33;
        to_neg(); chk1("refetch bus_req", breq, 1'b1); chk("refetch addr", baddr, 32'h204); chk("refetch data", if_data, 32'h33); to_next();
        idle_in();
        to_neg(); chk1("refetch done bus_req", breq, 1'b0); to_next();

        // Slow bus: ten unacknowledged cycles with requester inputs churning.
        mr = 1'b1; ma = 32'h300; msel = 4'hF;
        to_neg(); chk1("slow start stall", mem_stall, 1'b1); to_next();
        for (int k = 0; k < 10; k++) begin
            ma = $urandom; md = $urandom; msel = 4'($urandom); mwe = 1'($urandom);
            ifr = 1'($urandom); ifa = $urandom; bdata = $urandom;
            to_neg();
            chk($sformatf("slow%0d addr", k), baddr, 32'h300);
            chk($sformatf("slow%0d sel/we", k), {27'd0, bsel, bwe}, {27'd0, 4'hF, 1'b0});
            chk1($sformatf("slow%0d stall", k), mem_stall, 1'b1);
            chk1($sformatf("slow%0d bus_req", k), breq, 1'b1);
            to_next();
        end
        ifr = 1'b0; back = 1'b1; bdata = 32'h0BAD_F00D;
        to_neg(); chk1("slow ack stall", mem_stall, 1'b0); chk("slow ack data", mem_data, 32'h0BAD_F00D); to_next();
        idle_in();
        to_neg(); chk1("slow done bus_req", breq, 1'b0); to_next();

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            reset    = ($urandom_range(0, 199) == 0);
            stop_all = 6'($urandom);
            ifr      = ($urandom_range(0, 3) != 0);
            ifa      = $urandom;
            mr       = ($urandom_range(0, 2) == 0);
            mwe      = 1'($urandom);
            msel     = 4'($urandom);
            ma       = $urandom;
            md       = $urandom;
            back     = ($urandom_range(0, 2) == 0);
            bdata    = $urandom;
            to_neg();
            to_next();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
